// File: rtl/register_file_16.sv
// Sixteen-entry, 16-bit register file. R0 reads zero, reads are combinational and there is one write port.
// Define REGFILE_BYPASS_EN to forward the write data to a read port during a same-cycle write to the same address.
module register_file_16 #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]  WD,
  input  logic              WE,
  output logic [WIDTH-1:0]  RD1,
  output logic [WIDTH-1:0]  RD2
);

  localparam int NREG = 1 << ADDR_W;

  // R0 has no storage, so the register array only covers indices 1..NREG-1.
  logic [WIDTH-1:0] regs_q [1:NREG-1];
  logic [WIDTH-1:0] regs_d [1:NREG-1];
  logic [WIDTH-1:0] readView [NREG];

  always_comb begin
    for (int i = 1; i < NREG; i++) begin
      regs_d[i] = (WE && (WA == ADDR_W'(i))) ? WD : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    readView[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      readView[i] = regs_q[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset and for R0, because neither case ever stores the data.
  logic fwdValid;
  assign fwdValid = WE && !rst && (WA != '0);
  assign RD1 = (fwdValid && (WA == RA1)) ? WD : readView[RA1];
  assign RD2 = (fwdValid && (WA == RA2)) ? WD : readView[RA2];
`else
  assign RD1 = readView[RA1];
  assign RD2 = readView[RA2];
`endif

  waUnknownOnWrite: assert property (@(posedge clk) WE |-> !$isunknown(WA))
    else $error("register_file_16: WA is X/Z while WE is asserted");

endmodule

// File: tb/tb_register_file_16.sv
// Randomized self-checking bench for register_file_16. It compares every read port against an array-based model.
// Define REGFILE_BYPASS_EN here to match an RTL build that has the forward path.
module tb_register_file_16;

  logic        clk;
  logic        rst;
  logic [3:0]  RA1, RA2, WA;
  logic [15:0] WD;
  logic        WE;
  logic [15:0] RD1, RD2;

  int vectorCount = 0;
  int missCount   = 0;
  logic [15:0] model [16];

  register_file_16 #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .WA(WA),
    .WD(WD), .WE(WE), .RD1(RD1), .RD2(RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // The model value that a port should show before the coming edge, given the current inputs.
  function automatic logic [15:0] expRead(input logic [3:0] addr);
    if (addr == 4'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (WE && !rst && WA != 4'd0 && WA == addr) return WD;
`endif
    return model[addr];
  endfunction

  // Drive one cycle of inputs, check both ports before the edge, then advance the model across the edge.
  task automatic applyStimulus(input logic rstV, input logic weV, input logic [3:0] waV,
                               input logic [15:0] wdV, input logic [3:0] ra1V,
                               input logic [3:0] ra2V, input bit doCheck);
    rst = rstV; WE = weV; WA = waV; WD = wdV; RA1 = ra1V; RA2 = ra2V;
    #1;
    if (doCheck) begin
      checkOutput($sformatf("RD1[RA1=%0d]", ra1V), RD1, expRead(ra1V));
      checkOutput($sformatf("RD2[RA2=%0d]", ra2V), RD2, expRead(ra2V));
    end
    @(posedge clk);
    if (rstV) begin
      foreach (model[i]) model[i] = 16'h0000;
    end else if (weV && waV != 4'd0) begin
      model[waV] = wdV;
    end
    #1;
  endtask

  initial begin
    foreach (model[i]) model[i] = 16'h0000;
    rst = 1'b1; WE = 1'b0; WA = 4'd0; WD = 16'h0000; RA1 = 4'd0; RA2 = 4'd0;

    // The initial reset; register contents are undefined before it, so nothing is checked yet.
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd1, 1'b1);

    // A reset takes priority over a write that arrives in the same cycle.
    applyStimulus(1'b0, 1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd5, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'd5, 16'h1234, 4'd5, 4'd2, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd5, 16'h1234, 4'd5, 4'd5, 1'b1);
    checkOutput("resetClearsR5", RD1, 16'h0000);

    // Write every register, then sweep both ports across all addresses.
    for (int i = 1; i < 16; i++)
      applyStimulus(1'b0, 1'b1, 4'(i), 16'(16'h1111 * i), 4'(i), 4'(i - 1), 1'b1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 4'(i), 4'(15 - i), 1'b1);
      checkOutput($sformatf("sweepConst[%0d]", i), RD1, 16'(16'h1111 * i));
    end

    // A write to R0 must be discarded.
    applyStimulus(1'b0, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b1);
    checkOutput("r0Port2", RD2, 16'h0000);

    // The two ports read independently and feed the ALU OR stage.
    applyStimulus(1'b0, 1'b1, 4'd3, 16'h00F0, 4'd1, 4'd2, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'd9, 16'h0F0F, 4'd1, 4'd2, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd9, 1'b1);
    checkOutput("aluOr", RD1 | RD2, 16'h0FFF);

    // Read during a write to the same address on both ports.
    applyStimulus(1'b0, 1'b1, 4'd7, 16'hAAAA, 4'd0, 4'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'd7, 16'h5555, 4'd7, 4'd7, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 1'b1);
    checkOutput("rdwAfter", RD2, 16'h5555);

    // With WE low, the write port must have no effect.
    applyStimulus(1'b0, 1'b1, 4'd4, 16'h0042, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 4'd4, 16'h1234, 4'd4, 4'd4, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0000, 4'd4, 4'd0, 1'b1);
    checkOutput("weGating", RD1, 16'h0042);

    // Random traffic with occasional resets mid-stream.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(31) == 0), $urandom_range(1) == 1,
                    4'($urandom_range(15)), 16'($urandom),
                    4'($urandom_range(15)), 4'($urandom_range(15)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
